// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with a fixed number of wait states.
//
// A request is accepted when req_valid and req_ready are both high at a rising edge. The block
// then waits WAIT_CYCLES cycles and presents a single-cycle response. Addresses with any bit set
// above ADDR_BITS-1 are rejected with rsp_err and never touch storage.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   req_valid  - request presented
//   req_ready  - block is idle and can accept a request this cycle
//   req_we     - 1 = write, 0 = read
//   req_addr   - 16-bit word address
//   req_wdata  - write data
//   rsp_valid  - one-cycle pulse marking a completed transaction
//   rsp_rdata  - read data (0 for writes, errors and when rsp_valid is low)
//   rsp_err    - out-of-range address flag (0 when rsp_valid is low)
module dmem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Depth = 1 << ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [15:0]    addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    mem [Depth];

    logic                 accept;
    logic                 enter_resp;
    logic                 t_we;
    logic [15:0]          t_addr;
    logic [31:0]          t_wdata;
    logic                 t_in_range;
    logic [ADDR_BITS-1:0] t_idx;

    always_comb begin
        req_ready = (state_q == StIdle);
        accept    = req_valid && req_ready;

        // Fields of the transaction that completes on this edge. With zero wait states the
        // transaction enters RESP on its acceptance edge, so the live inputs are used.
        if (state_q == StIdle) begin
            t_we    = req_we;
            t_addr  = req_addr;
            t_wdata = req_wdata;
        end else begin
            t_we    = we_q;
            t_addr  = addr_q;
            t_wdata = wdata_q;
        end

        t_in_range = ((32'(t_addr) >> ADDR_BITS) == 32'd0);
        t_idx      = t_addr[ADDR_BITS-1:0];

        enter_resp = ((state_q == StWait) && (cnt_q == 4'd1)) ||
                     (accept && (WAIT_CYCLES == 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !t_in_range;
                if (!t_we && t_in_range) begin
                    rsp_rdata <= mem[t_idx];
                end
            end
        end
    end

    // Storage has no reset; a reset on the completing edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && t_we && t_in_range) begin
            mem[t_idx] <= t_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and one with none.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0;
    logic [15:0] req_addr0 = 16'd0;
    logic [31:0] req_wdata0 = 32'd0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    exp_t e_m;
    exp_t e_m0;

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor for the two-wait-state instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_rsp actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e_m = q.pop_front();
                    check({e_m.name, "_rdata"}, rsp_rdata, e_m.rdata);
                    check({e_m.name, "_err"}, {31'd0, rsp_err}, {31'd0, e_m.err});
                    check({e_m.name, "_cycle"}, cyc, e_m.cyc);
                    check({e_m.name, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
                end
            end else begin
                check("rsp_valid_known", {31'd0, rsp_valid}, 32'd0);
                check("idle_rdata", rsp_rdata, 32'd0);
                check("idle_err", {31'd0, rsp_err}, 32'd0);
            end
        end
    end

    // Monitor for the zero-wait-state instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_rsp0 actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e_m0 = q0.pop_front();
                    check({e_m0.name, "_rdata"}, rsp_rdata0, e_m0.rdata);
                    check({e_m0.name, "_err"}, {31'd0, rsp_err0}, {31'd0, e_m0.err});
                    check({e_m0.name, "_cycle"}, cyc, e_m0.cyc);
                end
            end else begin
                check("w0_rsp_valid_known", {31'd0, rsp_valid0}, 32'd0);
                check("w0_idle_rdata", rsp_rdata0, 32'd0);
                check("w0_idle_err", {31'd0, rsp_err0}, 32'd0);
            end
        end
    end

    // mode 0: normal; 1: toggle request fields while busy; 2: reset in WAIT;
    // 3: reset on the edge that would enter RESP. Modes 2 and 3 expect no response.
    task automatic issue(input string nm, input bit we, input logic [15:0] a,
                         input logic [31:0] d, input logic [31:0] er, input bit ee,
                         input int mode);
        bit got = 1'b0;
        exp_t x;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            failed++;
            $display("FAIL %s_accept_timeout actual=0 required=1", nm);
            req_valid = 1'b0;
            return;
        end
        if (mode < 2) begin
            x.rdata = er;
            x.err   = ee;
            x.cyc   = cyc + W + 1;
            x.name  = nm;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        if (mode == 1) begin
            for (int i = 0; i < W + 1; i++) begin
                req_valid = 1'b1;
                req_we    = i[0];
                req_wdata = d ^ 32'hFFFF_0000 ^ 32'(i);
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
        end else if (mode == 2 || mode == 3) begin
            req_valid = 1'b0;
            if (mode == 3) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check({nm, "_ready_after_rst"}, {31'd0, req_ready}, 32'd1);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic issue0(input string nm, input bit we, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] er, input bit ee);
        bit got = 1'b0;
        exp_t x;
        @(posedge clk);
        #1;
        req_valid0 = 1'b1;
        req_we0    = we;
        req_addr0  = a;
        req_wdata0 = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            failed++;
            $display("FAIL %s_accept_timeout actual=0 required=1", nm);
        end else begin
            x.rdata = er;
            x.err   = ee;
            x.cyc   = cyc + 1;
            x.name  = nm;
            q0.push_back(x);
        end
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (q.size() == 0 && q0.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size() + q0.size());
        end
        @(posedge clk);
    endtask

    task automatic burst();
        int acc = 0;
        int busy = 0;
        int last = -1;
        exp_t x;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0005;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc++;
                if (last >= 0) check("burst_spacing", cyc - last, W + 2);
                last    = cyc;
                x.rdata = 32'hDEAD_BEEF;
                x.err   = 1'b0;
                x.cyc   = cyc + W + 1;
                x.name  = "burst_rd";
                q.push_back(x);
            end else begin
                busy++;
            end
        end
        req_valid = 1'b0;
        check("burst_accepts", acc, 3);
        check("burst_busy_cycles", busy, 9);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_ready0", {31'd0, req_ready0}, 32'd1);
        mon_en = 1'b1;

        issue("wr5", 1'b1, 16'h0005, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        issue("rd5", 1'b0, 16'h0005, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        issue("wr0", 1'b1, 16'h0000, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        issue("wr_oor", 1'b1, 16'h0400, 32'h1234_5678, 32'h0, 1'b1, 0);
        issue("rd0", 1'b0, 16'h0000, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
        issue("rd_oor", 1'b0, 16'h0400, 32'h0, 32'h0, 1'b1, 0);
        issue("rd_ffff", 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, 0);
        issue("wr3ff", 1'b1, 16'h03FF, 32'h55AA_55AA, 32'h0, 1'b0, 0);
        issue("rd3ff", 1'b0, 16'h03FF, 32'h0, 32'h55AA_55AA, 1'b0, 0);
        drain();

        burst();
        drain();

        issue("wr10", 1'b1, 16'h0010, 32'h1111_1111, 32'h0, 1'b0, 0);
        issue("rst_wait", 1'b1, 16'h0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
        issue("rd10_a", 1'b0, 16'h0010, 32'h0, 32'h1111_1111, 1'b0, 0);
        issue("rst_resp", 1'b1, 16'h0010, 32'h2222_2222, 32'h0, 1'b0, 3);
        issue("rd10_b", 1'b0, 16'h0010, 32'h0, 32'h1111_1111, 1'b0, 0);
        issue("wr20_junk", 1'b1, 16'h0020, 32'hCAFE_0042, 32'h0, 1'b0, 1);
        issue("rd20", 1'b0, 16'h0020, 32'h0, 32'hCAFE_0042, 1'b0, 0);
        drain();

        issue0("w0_wr3", 1'b1, 16'h0003, 32'h0000_0077, 32'h0, 1'b0);
        issue0("w0_rd3", 1'b0, 16'h0003, 32'h0, 32'h0000_0077, 1'b0);
        issue0("w0_wr_oor", 1'b1, 16'h8003, 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue0("w0_rd3_again", 1'b0, 16'h0003, 32'h0, 32'h0000_0077, 1'b0);
        drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, SHALL set storage depth to 2**ADDR_BITS 32-bit words (legal 4..16).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set inserted wait states per transaction (legal 0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  1  SHALL indicate that a request is presented.
REQ-006 req_ready  output  1  SHALL indicate that the block can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-008 req_addr  input  16  SHALL carry the word address.
REQ-009 req_wdata  input  32  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL be the one-cycle pulse marking a completed transaction.
REQ-011 rsp_rdata  output  32  SHALL carry the read data, valid only while rsp_valid=1.
REQ-012 rsp_err  output  1  SHALL flag an out-of-range address, valid only while rsp_valid=1.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 req_ready SHALL equal (state==IDLE), combinationally.
REQ-015 Acceptance SHALL occur on an edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be captured on that edge.
REQ-016 Request inputs SHALL be ignored on any edge without acceptance.
REQ-017 On acceptance, if WAIT_CYCLES>0, the FSM SHALL go IDLE->WAIT and load the wait counter with WAIT_CYCLES.
REQ-018 On acceptance, if WAIT_CYCLES=0, the FSM SHALL go IDLE->RESP directly.
REQ-019 In WAIT, the counter SHALL decrement each edge; on the edge where the counter equals 1, the FSM SHALL go WAIT->RESP.
REQ-020 RESP SHALL last exactly one cycle and then go to IDLE unconditionally; there is no response backpressure.
REQ-021 rsp_valid SHALL be high exactly in RESP: WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-022 Address check: captured addr[15:ADDR_BITS] nonzero SHALL count as out-of-range.
REQ-023 For in-range addresses, only addr[ADDR_BITS-1:0] SHALL index storage.
REQ-024 In-range write SHALL commit mem[addr]=wdata on the edge entering RESP.
REQ-025 In-range write SHALL produce rsp_rdata=0 and rsp_err=0.
REQ-026 In-range read SHALL give rsp_rdata = mem[addr] as of the edge entering RESP, with rsp_err=0.
REQ-027 Out-of-range access SHALL NOT modify storage, and SHALL give rsp_err=1 and rsp_rdata=0.
REQ-028 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-029 Maximum throughput SHALL be one transaction per WAIT_CYCLES+2 cycles; the next acceptance is possible no earlier than the IDLE cycle after RESP.
REQ-030 A read following a write to the same address SHALL return the newly written data.
REQ-031 Storage SHALL be inferred as a synchronous single-port array with no initialisation requirement.

Reset
REQ-032 With rst=1 at an edge, the state SHALL become IDLE, the wait counter 0, and rsp_valid, rsp_rdata and rsp_err 0; storage contents are not reset.
REQ-033 rst SHALL take priority over acceptance: a request presented on a reset edge is dropped.
REQ-034 Reset in WAIT SHALL abandon the pending transaction: no commit, no rsp_valid pulse.
REQ-035 Reset on the edge that would enter RESP SHALL suppress the write commit.
REQ-036 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (ADDR_BITS=10, WAIT_CYCLES=2 unless stated)
REQ-037 Write 0xDEADBEEF @0x0005 accepted at edge N, then read @0x0005 -> write: rsp_valid only in cycle N+3, rdata=0, err=0; read: rdata=0xDEADBEEF, err=0.
REQ-038 Write 0x12345678 @0x0400 (out of range), then read @0x0000 -> write: err=1, rdata=0; read: returns prior mem[0] unchanged, err=0.
REQ-039 req_valid held high for 12 cycles with reads -> exactly 3 acceptances, each 4 cycles apart; req_ready low in WAIT and RESP.
REQ-040 Write 0xA5A5A5A5 @0x0010, rst pulsed for one cycle while in WAIT -> no rsp_valid; a subsequent read @0x0010 does not return 0xA5A5A5A5.
REQ-041 WAIT_CYCLES=0: read @0x0003 after write of 0x00000077 -> rsp_valid one cycle after each acceptance, read rdata=0x00000077.
REQ-042 Request fields toggled while req_ready=0 -> no effect on the in-flight response or on storage.
